// File: rtl/point_scalar_mult.sv
// Sequential elliptic-curve scalar multiplier R = k*G (MSB-first double-and-add, two cycles per bit)
// built around one combinational affine PointAdder; (0,0) encodes the point at infinity.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef MODULUS
`define MODULUS 17
`endif
`ifndef A
`define A 2
`endif

module PointAdder (
  input  logic [`DATAWIDTH-1:0] Px,
  input  logic [`DATAWIDTH-1:0] Py,
  input  logic [`DATAWIDTH-1:0] Qx,
  input  logic [`DATAWIDTH-1:0] Qy,
  output logic [`DATAWIDTH-1:0] Rx,
  output logic [`DATAWIDTH-1:0] Ry
);
  localparam int W = `DATAWIDTH;
  typedef logic [W-1:0]   fe_t;
  typedef logic [2*W-1:0] wide_t;
  localparam wide_t MOD = wide_t'(`MODULUS);

  function automatic fe_t mmul(input fe_t a, input fe_t b);
    wide_t prod;
    prod = wide_t'(a) * wide_t'(b);
    return fe_t'(prod % MOD);
  endfunction

  function automatic fe_t madd(input fe_t a, input fe_t b);
    wide_t s;
    s = wide_t'(a) + wide_t'(b);
    return fe_t'(s % MOD);
  endfunction

  function automatic fe_t msub(input fe_t a, input fe_t b);
    wide_t s;
    s = wide_t'(a) + MOD - wide_t'(b);
    return fe_t'(s % MOD);
  endfunction

  // Fermat inverse a^(p-2); the modulus is prime, and inv(0) falls out as 0
  function automatic fe_t minv(input fe_t a);
    wide_t e;
    fe_t   r;
    fe_t   b;
    e = MOD - wide_t'(2);
    r = fe_t'(1);
    b = a;
    for (int i = 0; i < 2*W; i++) begin
      if (e[i]) r = mmul(r, b);
      b = mmul(b, b);
    end
    return r;
  endfunction

  logic p_inf, q_inf, same_x, opp;
  fe_t  num, den, lam, x3, y3;

  always_comb begin
    p_inf  = (Px == '0) && (Py == '0);
    q_inf  = (Qx == '0) && (Qy == '0);
    same_x = (Px == Qx);
    opp    = (madd(Py, Qy) == '0);
    if (same_x) begin
      num = madd(mmul(fe_t'(3), mmul(Px, Px)), fe_t'(`A));
      den = madd(Py, Py);
    end else begin
      num = msub(Qy, Py);
      den = msub(Qx, Px);
    end
    lam = mmul(num, minv(den));
    x3  = msub(msub(mmul(lam, lam), Px), Qx);
    y3  = msub(mmul(lam, msub(Px, x3)), Py);
    Rx  = x3;
    Ry  = y3;
    if (p_inf) begin
      Rx = Qx;
      Ry = Qy;
    end else if (q_inf) begin
      Rx = Px;
      Ry = Py;
    end else if (same_x && opp) begin
      Rx = '0;
      Ry = '0;
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for start; Rx/Ry hold the last result
// DBL   | R <= 2R
// ADD   | R <= R+G when k[idx] is set, else R kept; step idx
// FIN   | done pulse, result final
module point_scalar_mult (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [`DATAWIDTH-1:0] k,
  input  logic [`DATAWIDTH-1:0] Gx,
  input  logic [`DATAWIDTH-1:0] Gy,
  output logic                  busy,
  output logic                  done,
  output logic [`DATAWIDTH-1:0] Rx,
  output logic [`DATAWIDTH-1:0] Ry
);
  localparam int W     = `DATAWIDTH;
  localparam int IDX_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, DBL, ADD, FIN} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     k_q, k_d;
  logic [W-1:0]     gx_q, gx_d, gy_q, gy_d;
  logic [W-1:0]     rx_q, rx_d, ry_q, ry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [W-1:0]     opq_x, opq_y, sum_x, sum_y;

  // Second operand is G during ADD and R itself otherwise (doubling)
  assign opq_x = (state_q == ADD) ? gx_q : rx_q;
  assign opq_y = (state_q == ADD) ? gy_q : ry_q;

  PointAdder u_adder (
    .Px (rx_q),
    .Py (ry_q),
    .Qx (opq_x),
    .Qy (opq_y),
    .Rx (sum_x),
    .Ry (sum_y)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          gx_d    = Gx;
          gy_d    = Gy;
          rx_d    = '0;
          ry_d    = '0;
          idx_d   = IDX_W'(W-1);
          busy_d  = 1'b1;
          state_d = DBL;
        end
      end
      DBL: begin
        rx_d    = sum_x;
        ry_d    = sum_y;
        state_d = ADD;
      end
      ADD: begin
        if (k_q[idx_q]) begin
          rx_d = sum_x;
          ry_d = sum_y;
        end
        if (idx_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = DBL;
        end
      end
      FIN: state_d = IDLE;
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Rx   = rx_q;
  assign Ry   = ry_q;
endmodule

// File: tb/tb_point_scalar_mult.sv
// Scoreboard bench for point_scalar_mult on y^2 = x^3 + 2x + 2 mod 17, base G = (5,1) of order 19.
module tb_point_scalar_mult;
  localparam int P      = 17;
  localparam int CA     = 2;
  localparam int LAT    = 17;
  localparam int PERIOD = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] k_i = '0, gx_i = '0, gy_i = '0;
  logic       busy, done;
  logic [7:0] Rx, Ry;

  point_scalar_mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .k     (k_i),
    .Gx    (gx_i),
    .Gy    (gy_i),
    .busy  (busy),
    .done  (done),
    .Rx    (Rx),
    .Ry    (Ry)
  );

  always #5 clk = ~clk;

  typedef struct { int ex; int ey; int acc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int n_done = 0;
  int last_done = -1;
  bit gap_check = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain affine group law, inverse found by search
  function automatic int md(input int a);
    return ((a % P) + P) % P;
  endfunction

  function automatic int inv(input int a);
    for (int i = 1; i < P; i++)
      if (md(a * i) == 1) return i;
    return 0;
  endfunction

  task automatic padd(input int x1, input int y1, input int x2, input int y2,
                      output int x3, output int y3);
    int lam;
    if (x1 == 0 && y1 == 0) begin x3 = x2; y3 = y2; end
    else if (x2 == 0 && y2 == 0) begin x3 = x1; y3 = y1; end
    else if (x1 == x2 && md(y1 + y2) == 0) begin x3 = 0; y3 = 0; end
    else begin
      if (x1 == x2) lam = md(md(3 * x1 * x1 + CA) * inv(md(2 * y1)));
      else          lam = md(md(y2 - y1) * inv(md(x2 - x1)));
      x3 = md(lam * lam - x1 - x2);
      y3 = md(lam * (x1 - x3) - y1);
    end
  endtask

  // k*G as k repeated additions
  task automatic ref_mul(input int kk, input int gx, input int gy, output int rx, output int ry);
    int ax, ay, tx, ty;
    ax = 0; ay = 0;
    for (int i = 0; i < kk; i++) begin
      padd(ax, ay, gx, gy, tx, ty);
      ax = tx; ay = ty;
    end
    rx = ax; ry = ay;
  endtask

  // Monitor: done seen at a falling edge is sampled by consumers on the next rising edge
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      check("busy_with_done", int'(busy), 0);
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_done: Rx=%0d Ry=%0d with no pending request", Rx, Ry);
      end else begin
        mon_e = sb.pop_front();
        check("Rx", int'(Rx), mon_e.ex);
        check("Ry", int'(Ry), mon_e.ey);
        check("latency", cyc + 1 - mon_e.acc, LAT);
        if (gap_check && last_done >= 0) check("done_gap", cyc - last_done, PERIOD);
      end
      last_done = cyc;
    end
  end

  task automatic issue(input int kk, input int gx, input int gy, input int ex, input int ey);
    @(negedge clk);
    k_i   = 8'(kk);
    gx_i  = 8'(gx);
    gy_i  = 8'(gy);
    start = 1'b1;
    sb.push_back('{ex, ey, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n_before);
    int t;
    t = 0;
    while (n_done == n_before && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (n_done == n_before) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", t);
    end
    @(negedge clk);
  endtask

  int dk[8] = '{1, 2, 5, 7, 18, 0, 19, 20};
  int dx[8] = '{5, 6, 9, 0, 5, 0, 0, 5};
  int dy[8] = '{1, 3, 16, 6, 16, 0, 0, 1};
  int hk[3] = '{3, 5, 7};
  int hx[3] = '{10, 9, 0};
  int hy[3] = '{6, 16, 6};

  initial begin
    int n0, m, kk, gx, gy, ex, ey, acc;

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_Rx", int'(Rx), 0);
    check("reset_Ry", int'(Ry), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      n0 = n_done;
      issue(dk[i], 5, 1, dx[i], dy[i]);
      wait_done(n0);
    end

    // start pulsed while busy plus operand changes mid-run
    n0 = n_done;
    issue(5, 5, 1, 9, 16);
    repeat (4) @(negedge clk);
    start = 1'b1; k_i = 8'd9; gx_i = 8'd7; gy_i = 8'd6;
    repeat (2) @(negedge clk);
    start = 1'b0; k_i = 8'($urandom);
    wait_done(n0);
    repeat (25) @(negedge clk);
    check("single_done", n_done - n0, 1);

    for (int i = 0; i < 8; i++) begin
      m  = $urandom_range(0, 18);
      ref_mul(m, 5, 1, gx, gy);
      kk = $urandom_range(0, 255);
      ref_mul(kk, gx, gy, ex, ey);
      n0 = n_done;
      issue(kk, gx, gy, ex, ey);
      repeat (3) @(negedge clk);
      k_i = 8'($urandom); gx_i = 8'($urandom); gy_i = 8'($urandom);
      wait_done(n0);
    end

    // reset in the middle of a k=7 run
    n0 = n_done;
    issue(7, 5, 1, 0, 6);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_Rx", int'(Rx), 0);
    check("abort_Ry", int'(Ry), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_done", n_done - n0, 0);
    n0 = n_done;
    issue(3, 5, 1, 10, 6);
    wait_done(n0);

    // start held high: back-to-back runs
    @(negedge clk);
    last_done = -1;
    gap_check = 1'b1;
    acc = cyc + 1;
    k_i = 8'(hk[0]); gx_i = 8'd5; gy_i = 8'd1;
    start = 1'b1;
    sb.push_back('{hx[0], hy[0], acc});
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < PERIOD; j++) begin
        @(negedge clk);
        check("busy_held", int'(busy), (j < 16) ? 1 : 0);
        if (j == 16) begin
          if (r < 2) begin
            k_i = 8'(hk[r+1]);
            sb.push_back('{hx[r+1], hy[r+1], acc + PERIOD});
          end else begin
            start = 1'b0;
          end
        end
      end
      acc = acc + PERIOD;
    end
    gap_check = 1'b0;
    repeat (25) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/point_scalar_mult.md
# point_scalar_mult

Sequential elliptic-curve scalar multiplier computing R = k·G by MSB-first double-and-add. It wraps exactly one combinational `PointAdder` instance, time-multiplexed between doubling (R+R) and addition (R+G), with a register stage after it. It sits directly downstream of the point adder. It is the primitive used by the ElGamal key-generation, encryption and decryption controllers. Execution is constant-time: every scalar bit costs exactly two cycles regardless of its value.

## Interface
- No Verilog parameters.
- Width is `` `DATAWIDTH `` and the curve constants (`` `A ``, modulus) come from `parameters.vh`.
- The point at infinity is encoded as (0,0), the same convention as `PointAdder`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `k`  in  `DATAWIDTH`  scalar; captured on start
- `Gx`  in  `DATAWIDTH`  base point x; captured on start
- `Gy`  in  `DATAWIDTH`  base point y; captured on start
- `busy`  out  1  high from the cycle after start acceptance until done
- `done`  out  1  one-cycle pulse; result valid
- `Rx`  out  `DATAWIDTH`  result x; registered, held until the next acceptance
- `Ry`  out  `DATAWIDTH`  result y; registered, held until the next acceptance

## Operation
- States are IDLE, DBL, ADD and FIN.
- Internal registers:
  - k_r (scalar copy)
  - gx_r, gy_r (base point copy)
  - rx_r, ry_r (accumulator R, drives Rx/Ry)
  - bit counter idx, width clog2(`DATAWIDTH`)
- Adder operand mux:
  - In DBL: P = Q = (rx_r, ry_r).
  - In ADD: P = (rx_r, ry_r), Q = (gx_r, gy_r).
  - Otherwise: don't care.
- IDLE, with start=1:
  - Latch k, Gx, Gy.
  - Set rx_r = ry_r = 0 (identity).
  - Set idx = `DATAWIDTH`-1.
  - Go to DBL.
- IDLE, with start=0: hold all state. Rx/Ry keep the last result.
- DBL: (rx_r, ry_r) <= adder output (2R). Go to ADD.
- ADD:
  - The adder always computes R+G.
  - If k_r[idx]=1, store the sum; otherwise keep R unchanged.
  - If idx==0, go to FIN. Otherwise decrement idx and go to DBL.
- FIN: done=1 for this cycle only. Go to IDLE.
- start outside IDLE is ignored; there is no queueing or restart.
- Inputs k/Gx/Gy may change freely after the acceptance edge.
- Special cases are delegated to `PointAdder` and need no extra logic here:
  - identity + X returns X;
  - X + (−X) returns the identity;
  - P==Q in ADD is treated as a double.
- k=0 gives (0,0).
- G=(0,0) gives (0,0) for every k.
- Scalars of order n or larger are not reduced here; the result is simply k·G.
- Rx/Ry change during computation because they expose rx_r. Consumers sample only on done.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, busy=0, done=0;
  - Rx=Ry=0, k_r=gx_r=gy_r=0, idx=0.
- Reset asserted mid-operation aborts immediately to the reset values. No done is issued.
- Acceptance edge: the rising edge on which state=IDLE and start=1. This edge is cycle 0.
- Cycles 1 … 2·`DATAWIDTH`: alternating DBL and ADD with busy=1.
- Cycle 2·`DATAWIDTH`+1: FIN; done=1, busy=0, Rx/Ry final.
  - Latency from acceptance to done is 2·`DATAWIDTH`+1 cycles.
- The earliest next acceptance is the edge ending FIN+1, i.e. when IDLE is observed. Back-to-back throughput is one result per 2·`DATAWIDTH`+2 cycles.
- busy and done are never high together.
- The critical path is the full `PointAdder` (ModDiv included) within one cycle. No multicycle constraints are assumed.

## Test plan
Bench configuration: `DATAWIDTH`=8, modulus 17, `A`=2 (curve y²=x³+2x+2 mod 17), G=(5,1), order 19.

- k=1 → done at exactly 17 cycles after acceptance, R=(5,1); k=2 → (6,3); k=5 → (9,16).
- k=7 → (0,6) (a legitimate x=0 point, not the identity); k=18 → (5,16), i.e. −G.
- k=0 → (0,0); k=19 → (0,0), exercising X+(−X) in the final ADD; k=20 → (5,1).
- Pulse start while busy, and change k/Gx/Gy mid-run:
  - the result matches the originally latched operands;
  - exactly one done pulse is produced.
- Assert rst_n low at cycle 9 of a k=7 run:
  - outputs go to zero immediately and no done is issued;
  - after release, a new k=3 run returns (10,6).
- Issue start held high continuously:
  - runs start back-to-back with done pulses 18 cycles apart;
  - busy is low only in FIN and the IDLE acceptance cycle.
